pid_controller_mux: RTL and testbench
=====================================

// Module: pid_controller_mux
// PURPOSE
//  Time-multiplexed integer PID for NUM_CH muscle channels sharing one multiplier.
//  Each channel has position, velocity, displacement or disabled mode, deadband, feed-forward,
//  anti-windup integral clamp, fixed-point scaling and output saturation.
//  Sits between the per-channel config/setpoint register file and the PWM generators.
//  One sweep over all channels runs per rising edge of update_controller.
// PARAMETERS
//  NUM_CH     8   number of channels
//  DATA_W     32  width of setpoint/position/error
//  GAIN_W     16  width of gains, limits, deadband
//  OUT_W      16  width of each pwm_ref
//  FRAC_BITS  0   arithmetic right shift applied to every gain product
// PORTS
//  clock              in   1             system clock
//  reset              in   1             asynchronous, active-high
//  cfg_we             in   1             config write strobe
//  cfg_ch             in   clog2(NUM_CH) config target channel
//  cfg_addr           in   4             0 Kp, 1 Ki, 2 Kd, 3 Kff, 4 sp, 5 outPosMax, 6 outNegMax, 7 intPosMax, 8 intNegMax, 9 deadband, 10 mode, 11 clear state
//  cfg_wdata          in   DATA_W        write data (low GAIN_W bits for gains/limits, [1:0] for mode)
//  position           in   NUM_CH*DATA_W signed, channel c at [c*DATA_W +: DATA_W]
//  velocity           in   NUM_CH*16     signed
//  displacement       in   NUM_CH*16     raw; bits [14:0] signed
//  update_controller  in   1             rising edge starts a sweep
//  pwm_ref            out  NUM_CH*OUT_W  signed, held between sweeps
//  out_valid          out  1             1-cycle pulse when out_ch's pwm_ref updates
//  out_ch             out  clog2(NUM_CH) channel just written
//  busy               out  1             high while a sweep is running
//  done               out  1             1-cycle pulse at sweep end
//  overrun            out  1             1-cycle pulse: update edge arrived while busy
// BEHAVIOUR
//  - Reset: pwm_ref, integrals, lastErrors, all gains/limits/sp/deadband = 0; mode = 3 (disabled).
//    out_valid, done, overrun, busy = 0; FSM = IDLE. Reset mid-sweep aborts it.
//  - Edge detect on registered update_controller. Edge in IDLE starts a sweep at ch 0.
//    Edge while busy: ignored, overrun pulses.
//  - FSM per channel: ERR -> MUL_P -> MUL_I -> MUL_D -> MUL_F -> SUM -> STORE (7 cycles).
//    STORE goes to ERR(ch+1), or to DONE after ch NUM_CH-1. DONE lasts 1 cycle: done=1, then IDLE.
//  - Sweep timing: the first ERR is 1 cycle after the edge is detected; done comes 7*NUM_CH+1 cycles after it.
//  - ERR samples that channel's measurements and snapshots its config. A cfg write to the channel
//    being processed is stored immediately but used from the next sweep.
//  - Error, sign-extended to DATA_W:
//    - mode 0: sp - position.
//    - mode 1: sp - velocity.
//    - mode 2: d = displacement[14:0] signed, negative d -> 0; err = sp>0 ? sp - d : 0.
//    - mode 3: pwm_ref = 0, integral and lastError cleared, no other math.
//  - Products are DATA_W+GAIN_W wide, then >>> FRAC_BITS (arithmetic, floor).
//  - |err| < deadband: pwm_ref = integral clamped to [outNegMax, outPosMax]; integral is unchanged.
//    In both branches lastError <= err.
//  - Otherwise:
//    - p = Kp*err.
//    - Anti-windup: integral += Ki*err only when outNegMax <= p <= outPosMax, then clamp to [intNegMax, intPosMax].
//    - d = Kd*(err - lastError); ff = Kff*sp.
//    - sum = p + i + d + ff with full-width accumulator, no wrap; clamp to [outNegMax, outPosMax]; truncate to OUT_W.
//  - STORE writes pwm_ref[ch] and pulses out_valid with out_ch = ch.
//  - Simultaneous: cfg_addr 11 to a channel clears its integral/lastError; if that channel is in SUM/STORE,
//    the clear wins over that cycle's update.
//  - cfg_we with cfg_ch >= NUM_CH or cfg_addr > 11 is ignored.
// TESTING
//  - Reset then an edge with all modes 3: 7*NUM_CH+1 cycles to done, NUM_CH out_valid pulses, all pwm_ref = 0.
//  - ch0 mode 0, Kp=2, sp=100, pos=40, limits +-1000: pwm_ref[0] = 120. Kd=1 on the first sweep -> 180; unchanged second sweep -> 120.
//  - ch1 mode 1, Ki=10, err=5, intPosMax=120, Kp=0: integral 50, 100, 120, 120 over four sweeps; pwm_ref follows.
//  - Saturation/anti-windup: Kp=100, err=50, outPosMax=1000 -> pwm_ref=1000 and integral unchanged. Deadband=10 with err=9 -> pwm_ref = integral.
//  - ch2 mode 2: displacement=16'h7FF0 (negative) -> d=0, sp=30, Kp=1 -> 30. sp=-5 -> err 0 -> pwm_ref=0.
//  - Second edge 3 cycles after the first -> overrun pulse, single done. Reset at cycle 10 of a sweep -> busy=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/pid_controller_mux.sv
// Time-multiplexed PID for NUM_CH channels sharing a single gain multiplier; one sweep per update_controller rising edge.
// Latency: 7 cycles per channel, done pulses 7*NUM_CH+1 cycles after the update edge is seen; out_valid 1 cycle after STORE.
// Backpressure: none; an update edge during a sweep is dropped and flagged by a 1-cycle overrun pulse.
module pid_controller_mux #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 32,
    parameter int GAIN_W    = 16,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 0,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [3:0]                cfg_addr,
    input  logic [DATA_W-1:0]         cfg_wdata,
    input  logic [NUM_CH*DATA_W-1:0]  position,
    input  logic [NUM_CH*16-1:0]      velocity,
    input  logic [NUM_CH*16-1:0]      displacement,
    input  logic                      update_controller,
    output logic [NUM_CH*OUT_W-1:0]   pwm_ref,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_ch,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);
    localparam int PW = DATA_W + GAIN_W;   // product width
    localparam int AW = PW + 3;            // accumulator width, never wraps for four terms

    typedef enum logic [3:0] {
        S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_MUL_D, S_MUL_F, S_SUM, S_STORE, S_DONE
    } state_t;

    state_t state, state_nxt;
    logic [CH_W-1:0] ch;
    logic upd_q, upd_edge, last_ch;

    // per-channel configuration and state
    logic signed [GAIN_W-1:0] kp_r [NUM_CH];
    logic signed [GAIN_W-1:0] ki_r [NUM_CH];
    logic signed [GAIN_W-1:0] kd_r [NUM_CH];
    logic signed [GAIN_W-1:0] kff_r [NUM_CH];
    logic signed [GAIN_W-1:0] opmax_r [NUM_CH];
    logic signed [GAIN_W-1:0] onmax_r [NUM_CH];
    logic signed [GAIN_W-1:0] ipmax_r [NUM_CH];
    logic signed [GAIN_W-1:0] inmax_r [NUM_CH];
    logic        [GAIN_W-1:0] db_r [NUM_CH];
    logic signed [DATA_W-1:0] sp_r [NUM_CH];
    logic        [1:0]        mode_r [NUM_CH];
    logic signed [DATA_W-1:0] integ_r [NUM_CH];
    logic signed [DATA_W-1:0] last_r [NUM_CH];
    logic signed [OUT_W-1:0]  pwm_r [NUM_CH];

    // snapshot of the channel being processed
    logic        [1:0]        w_mode;
    logic signed [DATA_W-1:0] w_err, w_sp, w_last, w_int;
    logic signed [GAIN_W-1:0] w_kp, w_ki, w_kd, w_kff, w_opmax, w_onmax, w_ipmax, w_inmax;
    logic        [GAIN_W-1:0] w_db;
    logic signed [PW-1:0]     p_r, i_r, d_r, ff_r;
    logic signed [OUT_W-1:0]  out_new;
    logic signed [DATA_W-1:0] int_new, last_new;
    logic                     clr_pend;

    logic cfg_hit, clr_cur;
    assign cfg_hit  = cfg_we && (int'(cfg_ch) < NUM_CH) && (cfg_addr <= 4'd11);
    assign clr_cur  = cfg_hit && (cfg_addr == 4'd11) && (cfg_ch == ch);
    assign upd_edge = update_controller && !upd_q;
    assign last_ch  = (ch == CH_W'(NUM_CH - 1));

    // error of the current channel from its live measurements and mode
    logic signed [DATA_W-1:0] pos_c, sp_c, disp_ext, err_c;
    logic signed [15:0]       vel_c;
    logic        [14:0]       disp_c;
    always_comb begin
        pos_c    = position[int'(ch)*DATA_W +: DATA_W];
        vel_c    = velocity[int'(ch)*16 +: 16];
        disp_c   = displacement[int'(ch)*16 +: 15];
        sp_c     = sp_r[ch];
        disp_ext = disp_c[14] ? '0 : DATA_W'(disp_c);
        err_c    = '0;
        case (mode_r[ch])
            2'd0:    err_c = sp_c - pos_c;
            2'd1:    err_c = sp_c - DATA_W'(vel_c);
            2'd2:    err_c = (sp_c > 0) ? sp_c - disp_ext : '0;
            default: err_c = '0;
        endcase
    end

    // shared multiplier operand select
    logic signed [DATA_W-1:0] mul_a;
    logic signed [GAIN_W-1:0] mul_b;
    logic signed [PW-1:0]     prod, prod_sh;
    always_comb begin
        mul_a = w_err;
        mul_b = w_kp;
        case (state)
            S_MUL_I: mul_b = w_ki;
            S_MUL_D: begin mul_a = w_err - w_last; mul_b = w_kd; end
            S_MUL_F: begin mul_a = w_sp; mul_b = w_kff; end
            default: ;
        endcase
    end
    assign prod    = PW'(mul_a) * PW'(mul_b);
    assign prod_sh = prod >>> FRAC_BITS;

    // deadband, anti-windup integration and output saturation
    logic signed [AW-1:0] p_x, i_x, d_x, ff_x, int_x, olo, ohi, ilo, ihi, db_x, err_abs;
    logic signed [AW-1:0] i_cand, i_clamp, i_next, pick, o_clamp;
    logic                 in_db, p_ok;
    always_comb begin
        p_x     = AW'(p_r);
        i_x     = AW'(i_r);
        d_x     = AW'(d_r);
        ff_x    = AW'(ff_r);
        int_x   = AW'(w_int);
        olo     = AW'(w_onmax);
        ohi     = AW'(w_opmax);
        ilo     = AW'(w_inmax);
        ihi     = AW'(w_ipmax);
        db_x    = AW'($signed({1'b0, w_db}));
        err_abs = (w_err < 0) ? -AW'(w_err) : AW'(w_err);
        in_db   = err_abs < db_x;
        p_ok    = (p_x >= olo) && (p_x <= ohi);
        i_cand  = int_x + (p_ok ? i_x : AW'(0));
        i_clamp = (i_cand > ihi) ? ihi : ((i_cand < ilo) ? ilo : i_cand);
        if (in_db) begin
            i_next = int_x;
            pick   = int_x;
        end else begin
            i_next = i_clamp;
            pick   = p_x + i_clamp + d_x + ff_x;
        end
        o_clamp = (pick > ohi) ? ohi : ((pick < olo) ? olo : pick);
    end

    // sweep state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // sweep sequencing and status outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:  if (upd_edge) state_nxt = S_ERR;
            S_ERR:   state_nxt = S_MUL_P;
            S_MUL_P: state_nxt = S_MUL_I;
            S_MUL_I: state_nxt = S_MUL_D;
            S_MUL_D: state_nxt = S_MUL_F;
            S_MUL_F: state_nxt = S_SUM;
            S_SUM:   state_nxt = S_STORE;
            S_STORE: state_nxt = last_ch ? S_DONE : S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // edge detect, channel counter and output pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upd_q     <= 1'b0;
            ch        <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            overrun   <= 1'b0;
        end else begin
            upd_q     <= update_controller;
            overrun   <= upd_edge && (state != S_IDLE);
            out_valid <= (state == S_STORE);
            if (state == S_STORE) out_ch <= ch;
            if (state == S_IDLE && upd_edge) ch <= '0;
            else if (state == S_STORE && !last_ch) ch <= ch + 1'b1;
        end
    end

    // working registers: snapshot at ERR, one product per MUL cycle, result at SUM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_mode <= 2'd3;
            {w_err, w_sp, w_last, w_int} <= '0;
            {w_kp, w_ki, w_kd, w_kff, w_opmax, w_onmax, w_ipmax, w_inmax, w_db} <= '0;
            {p_r, i_r, d_r, ff_r} <= '0;
            {out_new, int_new, last_new} <= '0;
            clr_pend <= 1'b0;
        end else begin
            clr_pend <= (state == S_ERR) ? clr_cur : (clr_pend || clr_cur);
            case (state)
                S_ERR: begin
                    w_mode  <= mode_r[ch];
                    w_err   <= err_c;
                    w_sp    <= sp_r[ch];
                    w_last  <= last_r[ch];
                    w_int   <= integ_r[ch];
                    w_kp    <= kp_r[ch];
                    w_ki    <= ki_r[ch];
                    w_kd    <= kd_r[ch];
                    w_kff   <= kff_r[ch];
                    w_opmax <= opmax_r[ch];
                    w_onmax <= onmax_r[ch];
                    w_ipmax <= ipmax_r[ch];
                    w_inmax <= inmax_r[ch];
                    w_db    <= db_r[ch];
                end
                S_MUL_P: p_r  <= prod_sh;
                S_MUL_I: i_r  <= prod_sh;
                S_MUL_D: d_r  <= prod_sh;
                S_MUL_F: ff_r <= prod_sh;
                S_SUM: begin
                    if (w_mode == 2'd3) begin
                        out_new  <= '0;
                        int_new  <= '0;
                        last_new <= '0;
                    end else begin
                        out_new  <= o_clamp[OUT_W-1:0];
                        int_new  <= i_next[DATA_W-1:0];
                        last_new <= w_err;
                    end
                end
                default: ;
            endcase
        end
    end

    // register file: config writes, state clears and per-channel results
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                kp_r[i]    <= '0;
                ki_r[i]    <= '0;
                kd_r[i]    <= '0;
                kff_r[i]   <= '0;
                opmax_r[i] <= '0;
                onmax_r[i] <= '0;
                ipmax_r[i] <= '0;
                inmax_r[i] <= '0;
                db_r[i]    <= '0;
                sp_r[i]    <= '0;
                mode_r[i]  <= 2'd3;
                integ_r[i] <= '0;
                last_r[i]  <= '0;
                pwm_r[i]   <= '0;
            end
        end else begin
            if (cfg_hit) begin
                case (cfg_addr)
                    4'd0:  kp_r[cfg_ch]    <= cfg_wdata[GAIN_W-1:0];
                    4'd1:  ki_r[cfg_ch]    <= cfg_wdata[GAIN_W-1:0];
                    4'd2:  kd_r[cfg_ch]    <= cfg_wdata[GAIN_W-1:0];
                    4'd3:  kff_r[cfg_ch]   <= cfg_wdata[GAIN_W-1:0];
                    4'd4:  sp_r[cfg_ch]    <= cfg_wdata;
                    4'd5:  opmax_r[cfg_ch] <= cfg_wdata[GAIN_W-1:0];
                    4'd6:  onmax_r[cfg_ch] <= cfg_wdata[GAIN_W-1:0];
                    4'd7:  ipmax_r[cfg_ch] <= cfg_wdata[GAIN_W-1:0];
                    4'd8:  inmax_r[cfg_ch] <= cfg_wdata[GAIN_W-1:0];
                    4'd9:  db_r[cfg_ch]    <= cfg_wdata[GAIN_W-1:0];
                    4'd10: mode_r[cfg_ch]  <= cfg_wdata[1:0];
                    4'd11: begin
                        integ_r[cfg_ch] <= '0;
                        last_r[cfg_ch]  <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == S_STORE) begin
                pwm_r[ch] <= out_new;
                // a clear seen at any point of this channel's pass beats the computed state
                if (!(clr_pend || clr_cur)) begin
                    integ_r[ch] <= int_new;
                    last_r[ch]  <= last_new;
                end
            end
        end
    end

    // flatten held outputs
    always_comb begin
        pwm_ref = '0;
        for (int c = 0; c < NUM_CH; c++) pwm_ref[c*OUT_W +: OUT_W] = pwm_r[c];
    end

    logic unused_bits;
    assign unused_bits = ^{cfg_wdata, displacement, o_clamp, i_next};
endmodule

// File: tb/tb_pid_controller_mux.sv
// Directed bench for pid_controller_mux: expected pwm_ref values are queued per sweep and popped on out_valid.
// Covers reset state, every mode, feed-forward, derivative, integral clamp, anti-windup, deadband, clears, overrun and mid-sweep reset.
module tb_pid_controller_mux;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 16;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     cfg_we;
    logic [2:0]               cfg_ch;
    logic [3:0]               cfg_addr;
    logic [DATA_W-1:0]        cfg_wdata;
    logic [NUM_CH*DATA_W-1:0] position;
    logic [NUM_CH*16-1:0]     velocity;
    logic [NUM_CH*16-1:0]     displacement;
    logic                     update_controller;
    logic [NUM_CH*OUT_W-1:0]  pwm_ref;
    logic                     out_valid;
    logic [2:0]               out_ch;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    pid_controller_mux dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .position(position), .velocity(velocity), .displacement(displacement),
        .update_controller(update_controller), .pwm_ref(pwm_ref), .out_valid(out_valid),
        .out_ch(out_ch), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_ch_q[$];
    logic [15:0] exp_val_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_all(input int v[NUM_CH]);
        for (int c = 0; c < NUM_CH; c++) begin
            exp_ch_q.push_back(c);
            exp_val_q.push_back(16'(v[c]));
        end
    endtask

    task automatic cfg_write(input int c, input int a, input int d);
        cfg_we = 1'b1; cfg_ch = 3'(c); cfg_addr = 4'(a); cfg_wdata = 32'(d);
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    // one sweep; optional second update edge at cycle edge2_k and optional cfg write at cycle wr_k
    task automatic sweep(input string tag, input int edge2_k, input int wr_k,
                         input int wr_ch, input int wr_addr, input int wr_data);
        int cyc = 0, done_cyc = -1, nvalid = 0, novr = 0, extra = 0;
        update_controller = 1'b1;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (out_valid) begin
                nvalid++;
                check({tag, " queue_nonempty"}, 32'(exp_ch_q.size() > 0), 1);
                if (exp_ch_q.size() > 0) begin
                    int ech;
                    logic [15:0] ev;
                    ech = exp_ch_q.pop_front();
                    ev  = exp_val_q.pop_front();
                    check({tag, " out_ch"}, 32'(out_ch), 32'(ech));
                    check($sformatf("%s pwm_ref[%0d]", tag, ech), 32'(pwm_ref[out_ch*OUT_W +: OUT_W]), 32'(ev));
                end
            end
            if (overrun) novr++;
            if (done) done_cyc = cyc;
            if (cyc == 1) begin
                update_controller = 1'b0;
                check({tag, " busy_running"}, 32'(busy), 1);
            end
            if (cyc == edge2_k)     update_controller = 1'b1;
            if (cyc == edge2_k + 1) update_controller = 1'b0;
            if (cyc == wr_k) begin
                cfg_we = 1'b1; cfg_ch = 3'(wr_ch); cfg_addr = 4'(wr_addr); cfg_wdata = 32'(wr_data);
            end
            if (cyc == wr_k + 1) cfg_we = 1'b0;
        end
        update_controller = 1'b0;
        cfg_we = 1'b0;
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(7 * NUM_CH + 1));
        check({tag, " valid_count"}, 32'(nvalid), NUM_CH);
        check({tag, " overrun_count"}, 32'(novr), (edge2_k > 0) ? 1 : 0);
        if (edge2_k > 0) begin
            for (int i = 0; i < 70; i++) begin
                @(negedge clock);
                if (done || out_valid) extra++;
            end
            check({tag, " no_second_sweep"}, 32'(extra), 0);
        end
        @(negedge clock);
        check({tag, " idle_after"}, 32'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        position = '0; velocity = '0; displacement = '0; update_controller = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset pwm_ref", 32'(pwm_ref == '0), 1);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset overrun", 32'(overrun), 0);

        // all channels disabled
        push_all('{0, 0, 0, 0, 0, 0, 0, 0});
        sweep("s0_disabled", 0, 0, 0, 0, 0);
        check("s0 all_zero", 32'(pwm_ref == '0), 1);

        // ch0 position mode with derivative
        cfg_write(0, 0, 2); cfg_write(0, 2, 1); cfg_write(0, 4, 100);
        cfg_write(0, 5, 1000); cfg_write(0, 6, -1000); cfg_write(0, 10, 0);
        position[0*32 +: 32] = 32'd40;
        // ch1 velocity mode, integral only
        cfg_write(1, 1, 10); cfg_write(1, 4, 20); cfg_write(1, 5, 1000); cfg_write(1, 6, -1000);
        cfg_write(1, 7, 120); cfg_write(1, 8, -120); cfg_write(1, 10, 1);
        velocity[1*16 +: 16] = 16'd15;
        // ch2 displacement mode, negative raw displacement
        cfg_write(2, 0, 1); cfg_write(2, 4, 30); cfg_write(2, 5, 1000); cfg_write(2, 6, -1000);
        cfg_write(2, 10, 2);
        displacement[2*16 +: 16] = 16'h7FF0;
        // ch3 positive saturation with anti-windup
        cfg_write(3, 0, 100); cfg_write(3, 1, 1); cfg_write(3, 4, 50); cfg_write(3, 5, 1000);
        cfg_write(3, 6, -1000); cfg_write(3, 7, 500); cfg_write(3, 8, -500); cfg_write(3, 10, 0);
        // ch4 negative saturation
        cfg_write(4, 0, 3); cfg_write(4, 4, -100); cfg_write(4, 5, 250); cfg_write(4, 6, -250);
        cfg_write(4, 10, 0);
        // ch5 feed-forward only
        cfg_write(5, 0, 1); cfg_write(5, 3, 2); cfg_write(5, 4, 7); cfg_write(5, 5, 1000);
        cfg_write(5, 6, -1000); cfg_write(5, 10, 0);
        position[5*32 +: 32] = 32'd7;

        push_all('{180, 50, 30, 1000, -250, 14, 0, 0});
        sweep("s1", 0, 0, 0, 0, 0);
        push_all('{120, 100, 30, 1000, -250, 14, 0, 0});
        sweep("s2", 0, 0, 0, 0, 0);
        push_all('{120, 120, 30, 1000, -250, 14, 0, 0});
        sweep("s3", 0, 0, 0, 0, 0);
        push_all('{120, 120, 30, 1000, -250, 14, 0, 0});
        sweep("s4", 0, 0, 0, 0, 0);

        // deadbands, negative setpoint in displacement mode, out-of-range address
        position[3*32 +: 32] = 32'd41;
        cfg_write(3, 9, 10); cfg_write(1, 9, 10); cfg_write(2, 4, -5); cfg_write(1, 12, 0);
        push_all('{120, 120, 0, 0, -250, 14, 0, 0});
        sweep("s5_deadband", 0, 0, 0, 0, 0);

        // clear ch1 state; positive displacement
        cfg_write(1, 11, 0); cfg_write(2, 4, 30);
        displacement[2*16 +: 16] = 16'h000A;
        push_all('{120, 0, 20, 0, -250, 14, 0, 0});
        sweep("s6_clear", 0, 0, 0, 0, 0);

        // clear of ch0 during its STORE cycle beats the update
        cfg_write(1, 9, 0);
        push_all('{120, 50, 20, 0, -250, 14, 0, 0});
        sweep("s7_clear_store", 0, 7, 0, 11, 0);

        // Kp write to ch0 while it is processed takes effect next sweep
        push_all('{180, 100, 20, 0, -250, 14, 0, 0});
        sweep("s8_midwrite", 0, 3, 0, 0, 3);
        push_all('{180, 120, 20, 0, -250, 14, 0, 0});
        sweep("s9", 0, 0, 0, 0, 0);

        // second edge 3 cycles in
        push_all('{180, 120, 20, 0, -250, 14, 0, 0});
        sweep("s10_overrun", 3, 0, 0, 0, 0);

        cfg_write(0, 10, 3);
        push_all('{0, 120, 20, 0, -250, 14, 0, 0});
        sweep("s11_disable", 0, 0, 0, 0, 0);

        // reset at cycle 10 of a sweep
        update_controller = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 1) update_controller = 1'b0;
        end
        check("pre_reset busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check("midreset busy", 32'(busy), 0);
        check("midreset pwm_ref", 32'(pwm_ref == '0), 1);
        check("midreset out_valid", 32'(out_valid), 0);
        check("midreset done", 32'(done), 0);
        check("midreset overrun", 32'(overrun), 0);
        reset = 1'b0;
        exp_ch_q.delete();
        exp_val_q.delete();
        @(negedge clock);

        // config returned to defaults: every channel disabled again
        push_all('{0, 0, 0, 0, 0, 0, 0, 0});
        sweep("s12_after_reset", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
